// File: rtl/ucsbece154a_mem_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory: writes finish in the grant cycle; reads return RD_LAT cycles later.
// Requesters wait with req held until gnt; while a read is outstanding no grants are issued.
module ucsbece154a_mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("ucsbece154a_mem_arbiter: RD_LAT must be in 1..4");
  end

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       owner;
  logic       rr_ptr;

  logic grant;
  logic both_req;
  logic sel;
  logic sel_we;
  logic rd_done;

  // Grants are suppressed while reset is asserted so nothing launches during reset.
  always_comb begin
    both_req = m0_req_i & m1_req_i;
    sel      = both_req ? rr_ptr : m1_req_i;
    grant    = reset & (state == IDLE) & (m0_req_i | m1_req_i);
    sel_we   = sel ? m1_we_i : m0_we_i;
    rd_done  = reset & (state == RD_WAIT) & (lat_cnt == 2'd0);
  end

  always_comb begin
    m0_gnt_o    = grant & ~sel;
    m1_gnt_o    = grant & sel;
    mem_en_o    = grant;
    mem_we_o    = grant & sel_we;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant) begin
      mem_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      mem_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  always_comb begin
    m0_rvalid_o = rd_done & ~owner;
    m1_rvalid_o = rd_done & owner;
    m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    busy_o      = (state == RD_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            // Priority only moves on contention; the loser goes first next time.
            if (both_req) rr_ptr <= ~sel;
            if (!sel_we) begin
              state   <= RD_WAIT;
              owner   <= sel;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 2'd0) state <= IDLE;
          else lat_cnt <= lat_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Directed bench: one arbiter per legal RD_LAT (index = RD_LAT-1) sharing the same stimulus.
module tb_ucsbece154a_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

  logic [3:0]  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy;
  logic [31:0] m0_rdata [4];
  logic [31:0] m1_rdata [4];
  logic [31:0] mem_addr [4];
  logic [31:0] mem_wdata [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ucsbece154a_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1)) dut (
      .clk(clk), .reset(reset),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(m0_gnt[g]), .m0_rvalid_o(m0_rvalid[g]), .m0_rdata_o(m0_rdata[g]),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt[g]), .m1_rvalid_o(m1_rvalid[g]), .m1_rdata_o(m1_rdata[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata), .busy_o(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n0;
    int n1;
    int w;
    logic [31:0] d;
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;

    // Reset held low, no requests
    tick; tick;
    mid;
    chk4("rst_m0_gnt", m0_gnt, 4'h0);
    chk4("rst_m1_gnt", m1_gnt, 4'h0);
    chk4("rst_rvalid", m0_rvalid | m1_rvalid, 4'h0);
    chk4("rst_mem_en", mem_en, 4'h0);
    chk4("rst_busy", busy, 4'h0);
    chk32("rst_mem_addr", mem_addr[0], 32'h0);
    m0_req = 1'b1;
    #1;
    chk4("rst_req_no_gnt", m0_gnt, 4'h0);
    m0_req = 1'b0;
    tick;

    // m0 read alone, RD_LAT=1 (instance 0)
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    mid;
    chk1("rd1_gnt", m0_gnt[0], 1'b1);
    chk1("rd1_mem_en", mem_en[0], 1'b1);
    chk32("rd1_mem_addr", mem_addr[0], 32'h100);
    chk1("rd1_busy_c0", busy[0], 1'b0);
    tick;
    m0_req = 1'b0;
    mid;
    chk1("rd1_rvalid", m0_rvalid[0], 1'b1);
    chk32("rd1_rdata", m0_rdata[0], 32'hDEADBEEF);
    chk1("rd1_busy_c1", busy[0], 1'b1);
    chk1("rd1_m1_rvalid", m1_rvalid[0], 1'b0);
    chk32("rd1_m1_rdata", m1_rdata[0], 32'h0);
    chk1("rd1_no_en_wait", mem_en[0], 1'b0);
    tick;
    mid;
    chk1("rd1_busy_c2", busy[0], 1'b0);
    chk1("rd1_rvalid_c2", m0_rvalid[0], 1'b0);
    chk32("rd1_rdata_c2", m0_rdata[0], 32'h0);
    repeat (5) tick;

    // Simultaneous writes: strict alternation starting with port 0
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h2;
    for (int k = 0; k < 4; k++) begin
      mid;
      chk4("wr_m0_gnt", m0_gnt, (k % 2 == 0) ? 4'hF : 4'h0);
      chk4("wr_m1_gnt", m1_gnt, (k % 2 == 1) ? 4'hF : 4'h0);
      chk4("wr_mem_we", mem_we, 4'hF);
      chk32("wr_mem_addr", mem_addr[0], (k % 2 == 0) ? 32'h10 : 32'h20);
      chk32("wr_mem_wdata", mem_wdata[0], (k % 2 == 0) ? 32'h1 : 32'h2);
      chk4("wr_busy", busy, 4'h0);
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    repeat (5) tick;

    // RD_LAT=3 (instance 2): m1 read, m0 write waits
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    mid;
    chk1("l3_m1_gnt", m1_gnt[2], 1'b1);
    chk32("l3_mem_addr", mem_addr[2], 32'h40);
    chk1("l3_mem_we", mem_we[2], 1'b0);
    tick;
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h55;
    mem_rdata = 32'hCAFE0040;
    for (int c = 1; c <= 3; c++) begin
      mid;
      chk1("l3_m0_gnt_wait", m0_gnt[2], 1'b0);
      chk1("l3_mem_en_wait", mem_en[2], 1'b0);
      chk1("l3_m1_rvalid", m1_rvalid[2], c == 3);
      chk1("l3_m0_rvalid", m0_rvalid[2], 1'b0);
      chk32("l3_m1_rdata", m1_rdata[2], (c == 3) ? 32'hCAFE0040 : 32'h0);
      tick;
    end
    mid;
    chk1("l3_m0_gnt_c4", m0_gnt[2], 1'b1);
    chk1("l3_mem_we_c4", mem_we[2], 1'b1);
    chk32("l3_mem_addr_c4", mem_addr[2], 32'h80);
    chk32("l3_mem_wdata_c4", mem_wdata[2], 32'h55);
    chk1("l3_m0_rvalid_c4", m0_rvalid[2], 1'b0);
    tick;
    m0_req = 1'b0; m0_we = 1'b0;
    repeat (5) tick;

    // Reset mid-read, RD_LAT=4 (instance 3)
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    mid;
    chk1("rm_m0_gnt", m0_gnt[3], 1'b1);
    tick;
    m0_req = 1'b0;
    mid;
    chk1("rm_busy_c1", busy[3], 1'b1);
    tick;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
    reset = 1'b0;
    #1;
    chk1("rm_busy_drop", busy[3], 1'b0);
    chk1("rm_m0_rvalid_rst", m0_rvalid[3], 1'b0);
    chk1("rm_m1_gnt_rst", m1_gnt[3], 1'b0);
    tick;
    reset = 1'b1;
    mid;
    chk1("rm_m1_gnt_after", m1_gnt[3], 1'b1);
    chk32("rm_mem_addr", mem_addr[3], 32'h300);
    chk1("rm_m0_rvalid_c3", m0_rvalid[3], 1'b0);
    tick;
    m1_req = 1'b0;
    mem_rdata = 32'hBEEF0300;
    for (int c = 4; c <= 7; c++) begin
      mid;
      chk1("rm_m0_rvalid", m0_rvalid[3], 1'b0);
      chk1("rm_m1_rvalid", m1_rvalid[3], c == 7);
      tick;
    end
    repeat (5) tick;

    // Fairness, RD_LAT=2 (instance 1), both ports reading continuously
    reset = 1'b0;
    tick;
    reset = 1'b1;
    n0 = 0; n1 = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000;
    for (int g = 0; g < 20; g++) begin
      w = g % 2;
      d = 32'hA0000000 + 32'(g);
      mid;
      chk1("fr_m0_gnt", m0_gnt[1], w == 0);
      chk1("fr_m1_gnt", m1_gnt[1], w == 1);
      chk32("fr_mem_addr", mem_addr[1], (w == 0) ? 32'h1000 : 32'h2000);
      n0 += int'(m0_gnt[1]);
      n1 += int'(m1_gnt[1]);
      tick;
      mid;
      chk1("fr_no_gnt_wait", m0_gnt[1] | m1_gnt[1], 1'b0);
      chk1("fr_no_rvalid_wait", m0_rvalid[1] | m1_rvalid[1], 1'b0);
      tick;
      mem_rdata = d;
      mid;
      chk1("fr_m0_rvalid", m0_rvalid[1], w == 0);
      chk1("fr_m1_rvalid", m1_rvalid[1], w == 1);
      chk32("fr_m0_rdata", m0_rdata[1], (w == 0) ? d : 32'h0);
      chk32("fr_m1_rdata", m1_rdata[1], (w == 1) ? d : 32'h0);
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk32("fr_m0_count", 32'(n0), 32'd10);
    chk32("fr_m1_count", 32'(n1), 32'd10);
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
